dsc_sn_decoder: RTL and testbench



---
 rtl/dsc_sn_decoder.sv | 144 ++++++++++++++
 tb/tb_dsc_sn_decoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dsc_sn_decoder.sv
// Frame-based stochastic-to-binary decoder: counts ones over 2^WIDTH enabled bits, valid/ready output.
// Optional thermometer-code checker on err enabled by macro DSC_SN_DECODER_ERR_CHK_EN.
module dsc_sn_decoder #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned OUT_WIDTH = WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 en,
    input  logic                 sn_in,
    output logic                 busy,
    output logic [OUT_WIDTH-1:0] bin_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err
);

    localparam int unsigned CW = WIDTH + 1;
    localparam logic [CW-1:0] CNT_LAST = {1'b0, {WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [OUT_WIDTH-1:0] r_acc;
    logic [OUT_WIDTH-1:0] r_bin;
    logic                 r_valid;
    logic                 r_busy;
    logic [OUT_WIDTH-1:0] w_sum;
    logic                 w_last;

    assign w_sum     = r_acc + OUT_WIDTH'(sn_in);
    assign w_last    = en && (r_cnt == CNT_LAST);
    assign busy      = r_busy;
    assign bin_out   = r_bin;
    assign out_valid = r_valid;

`ifdef DSC_SN_DECODER_ERR_CHK_EN
    logic r_seen_zero;
    logic r_frame_err;
    logic r_err;
    logic w_frame_err_nxt;

    // A one after any zero means the stream is not ones-then-zeros.
    assign w_frame_err_nxt = r_frame_err | (sn_in & r_seen_zero);
    assign err             = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seen_zero <= 1'b0;
            r_frame_err <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_seen_zero <= 1'b0;
                        r_frame_err <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (en) begin
                        r_seen_zero <= r_seen_zero | ~sn_in;
                        r_frame_err <= w_frame_err_nxt;
                        if (w_last) begin
                            r_err <= w_frame_err_nxt;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_err       <= 1'b0;
                        r_seen_zero <= 1'b0;
                        r_frame_err <= 1'b0;
                    end
                end
                default: begin
                    r_err <= 1'b0;
                end
            endcase
        end
    end
`else
    assign err = 1'b0;
`endif

    // Frame control, bit counting and result registration.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_bin   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ACCUM;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (en) begin
                        r_cnt <= r_cnt + CW'(1);
                        r_acc <= w_sum;
                        if (w_last) begin
                            r_bin   <= w_sum;
                            r_valid <= 1'b1;
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        if (start) begin
                            r_state <= S_ACCUM;
                            r_cnt   <= '0;
                            r_acc   <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsc_sn_decoder.sv
// Scoreboard bench for dsc_sn_decoder: expected frame results are queued at stimulus time
// and popped on each accepted output.
module tb_dsc_sn_decoder;

    localparam int unsigned WIDTH     = 4;
    localparam int unsigned OUT_WIDTH = WIDTH + 1;
    localparam int unsigned FRAME     = 1 << WIDTH;

    typedef struct packed {
        logic [OUT_WIDTH-1:0] bin;
        logic                 err;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 en;
    logic                 sn_in;
    logic                 busy;
    logic [OUT_WIDTH-1:0] bin_out;
    logic                 out_valid;
    logic                 out_ready;
    logic                 err;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    dsc_sn_decoder #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .en       (en),
        .sn_in    (sn_in),
        .busy     (busy),
        .bin_out  (bin_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int count_ones(input logic [FRAME-1:0] pat);
        int n = 0;
        for (int i = 0; i < int'(FRAME); i++) n += int'(pat[i]);
        return n;
    endfunction

    // Reference: a stream is well-formed if it is ones followed only by zeros.
    function automatic logic not_thermo(input logic [FRAME-1:0] pat);
        logic [FRAME-1:0] thermo;
        int n = count_ones(pat);
        thermo = '0;
        for (int i = 0; i < n; i++) thermo[i] = 1'b1;
        return (pat != thermo);
    endfunction

    // Check every accepted result against the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("bin_out", 32'(bin_out), 32'(e.bin));
                check_eq("err", 32'(err), 32'(e.err));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        en    = 1'b0;
        step();
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [FRAME-1:0] pat);
        exp_t e;
        e.bin = OUT_WIDTH'(count_ones(pat));
`ifdef DSC_SN_DECODER_ERR_CHK_EN
        e.err = not_thermo(pat);
`else
        e.err = 1'b0;
`endif
        sb_q.push_back(e);
    endtask

    // Feed the frame bits; gapped mode inserts two disabled cycles with sn_in=1 after each bit.
    task automatic feed_frame(input logic [FRAME-1:0] pat, input bit gapped);
        for (int i = 0; i < int'(FRAME); i++) begin
            en    = 1'b1;
            sn_in = pat[i];
            step();
            if (gapped && i != int'(FRAME) - 1) begin
                for (int g = 0; g < 2; g++) begin
                    en    = 1'b0;
                    sn_in = 1'b1;
                    step();
                end
            end
        end
        en    = 1'b0;
        sn_in = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [FRAME-1:0] pat, input bit gapped);
        do_start();
        push_exp(pat);
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        feed_frame(pat, gapped);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        step();
        check_eq({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; en = 1'b0; sn_in = 1'b0; out_ready = 1'b1;
        step(); step();
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_bin", 32'(bin_out), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        step();

        // IDLE ignores en/sn_in.
        en = 1'b1; sn_in = 1'b1;
        step(); step();
        check_eq("idle_ignore", 32'(busy), 32'd0);
        en = 1'b0; sn_in = 1'b0;

        run_frame("f11", 16'h07FF, 1'b0);
        run_frame("ones", 16'hFFFF, 1'b0);
        run_frame("zeros", 16'h0000, 1'b0);
        run_frame("gap8", 16'h5A3C, 1'b1);

        // Hold the result with out_ready low, then accept with a back-to-back start.
        out_ready = 1'b0;
        do_start();
        push_exp(16'h0FFF);
        feed_frame(16'h0FFF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_bin", 32'(bin_out), 32'd12);
            en = 1'b1; sn_in = 1'b1; start = (i == 2);
            step();
        end
        en = 1'b0; sn_in = 1'b0;
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        check_eq("b2b_valid", 32'(out_valid), 32'd0);
        check_eq("b2b_busy", 32'(busy), 32'd1);
        push_exp(16'h0007);
        feed_frame(16'h0007, 1'b0);
        check_eq("b2b_valid2", 32'(out_valid), 32'd1);
        step();
        check_eq("b2b_done", 32'(busy), 32'd0);

        // Reset in the middle of a frame discards the partial count.
        do_start();
        for (int i = 0; i < 9; i++) begin
            en = 1'b1; sn_in = 1'b1;
            step();
        end
        rst = 1'b1; en = 1'b1;
        step();
        rst = 1'b0; en = 1'b0;
        check_eq("mrst_valid", 32'(out_valid), 32'd0);
        check_eq("mrst_busy", 32'(busy), 32'd0);
        check_eq("mrst_bin", 32'(bin_out), 32'd0);
        check_eq("mrst_err", 32'(err), 32'd0);
        run_frame("after_rst", 16'h003F, 1'b0);

        run_frame("err_bad", 16'h000B, 1'b0);
        run_frame("err_ok", 16'h000F, 1'b0);

        step();
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
